d3s_phase_splitter: RTL



---
 rtl/d3s_phase_pkg.sv | 19 +
 rtl/d3s_phase_splitter_if.sv | 25 ++
 rtl/d3s_phase_lane_interp.sv | 21 ++
 rtl/d3s_phase_splitter.sv | 93 +++++++++
 4 files changed

// File: rtl/d3s_phase_pkg.sv
// Shared constants, FSM encoding and lane-slice helper for the D3S phase splitter.
package d3s_phase_pkg;

  localparam int C_ACC_BITS = 23;
  localparam int C_OUT_BITS = 14;
  localparam int C_LANES    = 4;
  localparam int C_CNT_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  function automatic int lane_lsb(input int k);
    return k * C_OUT_BITS;
  endfunction

endpackage

// File: rtl/d3s_phase_splitter_if.sv
// Control/status bundle between the WR-link side and the phase splitter.
interface d3s_phase_splitter_if;
  import d3s_phase_pkg::*;

  logic                          r_enable_i;
  logic [C_ACC_BITS-1:0]         phase_i;
  logic [C_ACC_BITS-1:0]         freq_i;
  logic                          phase_load_i;
  logic [C_LANES*C_OUT_BITS-1:0] phase_divided_o;
  logic                          phase_valid_o;
  logic                          slip_o;
  logic [C_CNT_BITS-1:0]         slip_cnt_o;
  logic [1:0]                    state_o;

  modport master (
    output r_enable_i, phase_i, freq_i, phase_load_i,
    input  phase_divided_o, phase_valid_o, slip_o, slip_cnt_o, state_o
  );

  modport slave (
    input  r_enable_i, phase_i, freq_i, phase_load_i,
    output phase_divided_o, phase_valid_o, slip_o, slip_cnt_o, state_o
  );

endinterface

// File: rtl/d3s_phase_lane_interp.sv
// One interpolated sub-sample lane: ((acc<<2) + k*freq) >> 2, top bits sliced out.
module d3s_phase_lane_interp
  import d3s_phase_pkg::*;
#(
  parameter int G_LANE = 0
) (
  input  logic [C_ACC_BITS-1:0] i_acc,
  input  logic [C_ACC_BITS-1:0] i_freq,
  output logic [C_OUT_BITS-1:0] o_lane
);

  logic [C_ACC_BITS+1:0]              w_kfreq;
  logic [C_ACC_BITS+1:0]              w_sum;
  logic [C_ACC_BITS+2-C_OUT_BITS-1:0] w_unused_lo;

  // 25-bit sum wraps naturally; dropping the 2 LSBs is the >>2
  assign w_kfreq = {2'b00, i_freq} * (C_ACC_BITS+2)'(G_LANE);
  assign w_sum   = {i_acc, 2'b00} + w_kfreq;
  assign {o_lane, w_unused_lo} = w_sum;

endmodule

// File: rtl/d3s_phase_splitter.sv
// Regenerates the local phase accumulator from WR snapshots, emits four
// interpolated lanes per clock and counts accumulator slips.
//
// state        | meaning
// IDLE         | disabled, acc/freq cleared
// WAIT_LOAD    | enabled, waiting for the first snapshot
// RUN          | accumulating, lanes valid next cycle, loads slip-checked
module d3s_phase_splitter
  import d3s_phase_pkg::*;
#(
  parameter int g_max_slip = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  d3s_phase_splitter_if.slave  bus
);

  state_t                        r_state, w_state_nxt;
  logic [C_ACC_BITS-1:0]         r_acc, r_freq, w_acc_nxt, w_freq_nxt;
  logic [C_ACC_BITS-1:0]         w_pred, w_diff;
  logic                          w_load_ok, w_slip_det;
  logic [C_LANES*C_OUT_BITS-1:0] w_lanes, r_lanes;
  logic                          r_valid, r_slip;
  logic [C_CNT_BITS-1:0]         r_slip_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_freq_nxt  = r_freq;
    w_load_ok   = 1'b0;
    if (!bus.r_enable_i) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_freq_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE:      w_state_nxt = ST_WAIT_LOAD;
        ST_WAIT_LOAD: if (bus.phase_load_i) begin
                        w_state_nxt = ST_RUN;
                        w_load_ok   = 1'b1;
                      end
        ST_RUN:       if (bus.phase_load_i) w_load_ok = 1'b1;
                      else                  w_acc_nxt = r_acc + r_freq;
        default:      w_state_nxt = ST_IDLE;
      endcase
      if (w_load_ok) begin
        w_acc_nxt  = bus.phase_i;
        w_freq_nxt = bus.freq_i;
      end
    end
  end

  // Difference is taken modulo 2^23 and read as signed, so wrap-around is not a slip
  assign w_pred     = r_acc + r_freq;
  assign w_diff     = bus.phase_i - w_pred;
  assign w_slip_det = w_load_ok && (r_state == ST_RUN) &&
                      (($signed(w_diff) > g_max_slip) || ($signed(w_diff) < -g_max_slip));

  for (genvar k = 0; k < C_LANES; k++) begin : g_lane
    d3s_phase_lane_interp #(.G_LANE(k)) u_lane (
      .i_acc  (r_acc),
      .i_freq (r_freq),
      .o_lane (w_lanes[lane_lsb(k) +: C_OUT_BITS])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_freq     <= '0;
      r_lanes    <= '0;
      r_valid    <= 1'b0;
      r_slip     <= 1'b0;
      r_slip_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_freq  <= w_freq_nxt;
      r_lanes <= w_lanes;
      r_valid <= (r_state == ST_RUN);
      r_slip  <= w_slip_det;
      if (w_slip_det && (r_slip_cnt != '1)) r_slip_cnt <= r_slip_cnt + 16'd1;
    end
  end

  assign bus.phase_divided_o = r_lanes;
  assign bus.phase_valid_o   = r_valid;
  assign bus.slip_o          = r_slip;
  assign bus.slip_cnt_o      = r_slip_cnt;
  assign bus.state_o         = r_state;

endmodule
